// File: rtl/output_flow_control.sv
// Credit-based transmit flow controller for one router output port.
// Optional sticky overflow flag on credit_err is enabled by defining OFC_ERR_EN.
module output_flow_control #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CREDITS    = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_val,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  ret,
    output logic [CNT_W-1:0]      credit_cnt,
    output logic                  credit_err
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(CREDITS);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  val_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  send;
    logic                  at_max;

    // Ready is a pure decode of the count flops, independent of ret this cycle.
    assign in_ready = (cnt_q != '0);
    assign send     = in_valid & in_ready;
    assign at_max   = (cnt_q == MaxCnt);

    always_comb begin
        cnt_d = cnt_q;
        case ({send, ret})
            2'b10:   cnt_d = cnt_q - 1'b1;
            2'b01:   if (!at_max) cnt_d = cnt_q + 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= MaxCnt;
            val_q  <= 1'b0;
            data_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            val_q <= send;
            if (send) begin
                data_q <= in_data;
            end
        end
    end

    assign credit_cnt = cnt_q;
    assign out_val    = val_q;
    assign out_data   = data_q;

`ifdef OFC_ERR_EN
    logic err_q;

    // A return with no send while already full means the receiver over-returned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (ret && !send && at_max) begin
            err_q <= 1'b1;
        end
    end

    assign credit_err = err_q;
`else
    assign credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_output_flow_control.sv
// Self-checking bench for output_flow_control: vector table, reset, random model, loopback.
module tb_output_flow_control;

`ifdef OFC_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    localparam int C4 = 4;
    localparam int C2 = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        out_val;
    logic [15:0] out_data;
    logic        ret = 1'b0;
    logic [3:0]  credit_cnt;
    logic        credit_err;

    logic        v2 = 1'b0;
    logic [15:0] d2 = '0;
    logic        rdy2;
    logic        ov2;
    logic [15:0] od2;
    logic        r2 = 1'b0;
    logic [3:0]  cnt2;
    logic        err2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    output_flow_control #(.DATA_WIDTH(16), .CREDITS(C4), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_val(out_val), .out_data(out_data), .ret(ret),
        .credit_cnt(credit_cnt), .credit_err(credit_err)
    );

    output_flow_control #(.DATA_WIDTH(16), .CREDITS(C2), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_data(d2),
        .in_ready(rdy2), .out_val(ov2), .out_data(od2), .ret(r2),
        .credit_cnt(cnt2), .credit_err(err2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        r;
        logic        ov;
        logic [15:0] od;
        logic [3:0]  cnt;
        logic        rdy;
        logic        err;
    } vec_t;

    vec_t tbl[22];

    task automatic do_reset();
        in_valid = 1'b0; ret = 1'b0; v2 = 1'b0; r2 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int m_cnt;
        bit m_err;
        bit m_ov;
        logic [15:0] m_od;
        bit snd;
        bit h4[3];
        bit h2[3];
        int sent4, sent2, rcv4, rcv2, stall4, stall2, extra, cyc;

        // Drain, resume, simultaneous send+return, full-with-send, overflow.
        tbl[0]  = '{1'b1, 16'h0001, 1'b0, 1'b1, 16'h0001, 4'd3, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 16'h0002, 1'b0, 1'b1, 16'h0002, 4'd2, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 16'h0003, 1'b0, 1'b1, 16'h0003, 4'd1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 16'h0004, 1'b0, 1'b1, 16'h0004, 4'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 16'h0005, 1'b0, 1'b0, 16'h0004, 4'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 16'h0006, 1'b0, 1'b0, 16'h0004, 4'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 16'h0005, 1'b1, 1'b0, 16'h0004, 4'd1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 16'h0005, 1'b0, 1'b1, 16'h0005, 4'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005, 4'd1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005, 4'd2, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 16'h00a0, 1'b1, 1'b1, 16'h00a0, 4'd2, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 16'h00a1, 1'b1, 1'b1, 16'h00a1, 4'd2, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 16'h00a2, 1'b1, 1'b1, 16'h00a2, 4'd2, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 16'h00a3, 1'b1, 1'b1, 16'h00a3, 4'd2, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 16'h00a4, 1'b1, 1'b1, 16'h00a4, 4'd2, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h00a4, 4'd2, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h00a4, 4'd3, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h00a4, 4'd4, 1'b1, 1'b0};
        tbl[18] = '{1'b1, 16'h00b0, 1'b1, 1'b1, 16'h00b0, 4'd4, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h00b0, 4'd4, 1'b1, ErrEn};
        tbl[20] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h00b0, 4'd4, 1'b1, ErrEn};
        tbl[21] = '{1'b1, 16'h00c0, 1'b0, 1'b1, 16'h00c0, 4'd3, 1'b1, ErrEn};

        do_reset();
        check("rst_cnt", 32'(credit_cnt), C4);
        check("rst_val", 32'(out_val), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_ready", 32'(in_ready), 1);
        check("rst_err", 32'(credit_err), 0);

        for (int i = 0; i < 22; i++) begin
            in_valid = tbl[i].v; in_data = tbl[i].d; ret = tbl[i].r;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_val", i), 32'(out_val), 32'(tbl[i].ov));
            check($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].od));
            check($sformatf("vec%0d_cnt", i), 32'(credit_cnt), 32'(tbl[i].cnt));
            check($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            check($sformatf("vec%0d_err", i), 32'(credit_err), 32'(tbl[i].err));
        end

        // Reset asserted mid-cycle with a flit on the link must clear state at once.
        in_valid = 1'b1; in_data = 16'h0055; ret = 1'b0;
        @(posedge clk);
        #2;
        check("mid_pre_val", 32'(out_val), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cnt", 32'(credit_cnt), C4);
        check("mid_rst_val", 32'(out_val), 0);
        check("mid_rst_ready", 32'(in_ready), 1);
        check("mid_rst_err", 32'(credit_err), 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic against an arithmetic credit model.
        m_cnt = C4; m_err = 1'b0; m_ov = 1'b0; m_od = 16'h0000;
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 99) < 70);
            ret = ($urandom_range(0, 99) < 45);
            in_data = 16'($urandom);
            check("rnd_ready", 32'(in_ready), 32'(m_cnt > 0));
            snd = in_valid && (m_cnt > 0);
            m_cnt = m_cnt - int'(snd) + int'(ret);
            if (m_cnt > C4) begin
                m_cnt = C4;
                if (ErrEn) m_err = 1'b1;
            end
            m_ov = snd;
            if (snd) m_od = in_data;
            @(posedge clk);
            #1;
            check("rnd_val", 32'(out_val), 32'(m_ov));
            check("rnd_data", 32'(out_data), 32'(m_od));
            check("rnd_cnt", 32'(credit_cnt), 32'(m_cnt));
            check("rnd_err", 32'(credit_err), 32'(m_err));
        end

        // Loopback: ret is out_val delayed by three cycles on both instances.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            h4[k] = 1'b0; h2[k] = 1'b0;
        end
        sent4 = 0; sent2 = 0; rcv4 = 0; rcv2 = 0; stall4 = 0; stall2 = 0; extra = 0; cyc = 0;
        while (cyc < 1000 && (rcv4 < 100 || rcv2 < 100 || extra < 6)) begin
            in_valid = (sent4 < 100); in_data = 16'(sent4 + 1); ret = h4[2];
            v2 = (sent2 < 100); d2 = 16'(sent2 + 1); r2 = h2[2];
            if (in_valid && in_ready) sent4++;
            if (in_valid && !in_ready) stall4++;
            if (v2 && rdy2) sent2++;
            if (v2 && !rdy2) stall2++;
            @(posedge clk);
            #1;
            if (out_val) begin
                check("loop4_data", 32'(out_data), 32'(rcv4 + 1));
                rcv4++;
            end
            if (ov2) begin
                check("loop2_data", 32'(od2), 32'(rcv2 + 1));
                rcv2++;
            end
            h4[2] = h4[1]; h4[1] = h4[0]; h4[0] = out_val;
            h2[2] = h2[1]; h2[1] = h2[0]; h2[0] = ov2;
            if (rcv4 >= 100 && rcv2 >= 100) extra++;
            cyc++;
        end
        check("loop4_count", 32'(rcv4), 100);
        check("loop2_count", 32'(rcv2), 100);
        check("loop4_no_stall", 32'(stall4), 0);
        check("loop2_stalled", 32'(stall2 > 0), 1);
        check("loop4_cnt_restored", 32'(credit_cnt), C4);
        check("loop2_cnt_restored", 32'(cnt2), C2);
        check("loop4_err", 32'(credit_err), 0);
        check("loop2_err", 32'(err2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
